axil_ram_strb: RTL and testbench
================================

Name: axil_ram_strb

Overview:
- Parametrised AXI4-Lite slave RAM, successor to the fixed-geometry AXI-Lite RAM.
- Generalises data width and depth, and adds WSTRB byte-lane writes.
- Accepts AW and W independently, in any order.
- Decodes byte addresses to word indices and returns SLVERR for out-of-range accesses.
- Used as scratch/config memory behind the AXI-Lite interconnect.

Parameters:
DATA_WIDTH, 32, data bus width in bits; must be 32 or 64.
ADDR_WIDTH, 16, byte address width.
DEPTH, 1024, number of DATA_WIDTH-bit words; must be at least 2 and at most 2^(ADDR_WIDTH-log2(DATA_WIDTH/8)).

Ports:
aclk  in  1  clock; all logic on rising edge.
aresetn  in  1  asynchronous, active-low reset.
s_axil_awaddr  in  ADDR_WIDTH  write byte address.
s_axil_awvalid  in  1  write address valid.
s_axil_awready  out  1  write address ready.
s_axil_wdata  in  DATA_WIDTH  write data.
s_axil_wstrb  in  DATA_WIDTH/8  byte-lane enables.
s_axil_wvalid  in  1  write data valid.
s_axil_wready  out  1  write data ready.
s_axil_bresp  out  2  write response.
s_axil_bvalid  out  1  write response valid.
s_axil_bready  in  1  write response ready.
s_axil_araddr  in  ADDR_WIDTH  read byte address.
s_axil_arvalid  in  1  read address valid.
s_axil_arready  out  1  read address ready.
s_axil_rdata  out  DATA_WIDTH  read data.
s_axil_rresp  out  2  read response.
s_axil_rvalid  out  1  read data valid.
s_axil_rready  in  1  read data ready.

Behaviour:
- Reset (aresetn low, asynchronous):
  - All ready/valid outputs 0; bresp, rresp, rdata = 0.
  - Write and read FSMs go to IDLE; AW/W holding flags cleared.
  - Memory array is not reset.
  - awready, wready, arready register to 1 on the first edge after aresetn rises.
- Address decode:
  - word index = addr >> log2(DATA_WIDTH/8); low byte-offset bits are ignored.
  - index >= DEPTH is out of range: resp = 2'b10 (SLVERR), no memory update, rdata = 0.
  - In range: resp = 2'b00.
- Write FSM, states W_IDLE, W_COMMIT, W_RESP:
  - W_IDLE:
    - AW handshake (awvalid & awready) latches awaddr, sets aw_held, clears awready.
    - W handshake latches wdata/wstrb, sets w_held, clears wready.
    - Handshakes may occur in the same cycle or in either order, any number of cycles apart.
    - When both are held (including both in the same edge), go to W_COMMIT.
  - W_COMMIT, one cycle:
    - For in-range addresses, each byte lane i with wstrb[i]=1 is written; other lanes are unchanged.
    - wstrb = 0 writes nothing and responds OKAY.
    - bvalid <= 1, bresp set per decode; go to W_RESP.
  - W_RESP:
    - bvalid and bresp held stable until bready.
    - On the bvalid & bready edge: bvalid <= 0, held flags cleared, awready/wready <= 1, go to W_IDLE.
  - Latency: bvalid rises 2 edges after the later of the AW/W handshakes.
- Read FSM, states R_IDLE, R_DATA:
  - R_IDLE: on the AR handshake edge, arready <= 0 and the address is latched.
  - Next edge: rdata <= mem[index] (or 0), rresp set, rvalid <= 1; go to R_DATA.
  - R_DATA: rdata, rresp, rvalid held stable while rready = 0.
  - On the rvalid & rready edge: rvalid <= 0, rdata <= 0, arready <= 1, go to R_IDLE.
- Read and write channels are fully independent.
- Write commit and read capture to the same word on the same edge: read returns the pre-write value.
- Reset asserted mid-transaction: pending AW/W/AR are discarded, no memory write occurs unless the W_COMMIT edge already passed, no response is issued after reset release.

Test Plan:
- Single write then read: AW 0x0010 and W 0xDEADBEEF with wstrb 0xF in the same cycle -> bvalid 2 edges later, bresp 00; read 0x0010 -> rdata 0xDEADBEEF, rresp 00, rvalid 1 edge after AR handshake.
- Byte strobes: word 0x0020 = 0x11223344, then write 0xAABBCCDD with wstrb 0b0101 -> read returns 0x11BB33DD.
- Decoupled order: W presented 5 cycles before AW, with bready held low 3 cycles -> wready drops after the W handshake, bvalid stays stable until bready, then awready and wready return to 1.
- Out of range (DEPTH=1024, 32-bit): write 0x1000 -> bresp 10, memory unchanged; read 0x1000 -> rdata 0, rresp 10.
- Backpressure and collision: rready low 4 cycles -> rdata stable; a read and a write to the same word in flight simultaneously -> read returns the old value.
- Reset mid-write: AW handshake completes, W not yet sent, aresetn pulsed low -> all outputs 0 immediately, ready signals 1 after release, a subsequent read of that word shows the old data.

Source files
------------

// File: rtl/axil_ram_strb.sv
// AXI4-Lite slave RAM with byte-lane strobes, independent AW/W capture and SLVERR decode.
// bvalid 2 edges after the later of AW/W, rvalid 1 edge after AR; each channel stalls until its response is taken.
module axil_ram_strb #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 16,
  parameter int DEPTH      = 1024
) (
  input  logic                    aclk,
  input  logic                    aresetn,
  input  logic [ADDR_WIDTH-1:0]   s_axil_awaddr,
  input  logic                    s_axil_awvalid,
  output logic                    s_axil_awready,
  input  logic [DATA_WIDTH-1:0]   s_axil_wdata,
  input  logic [DATA_WIDTH/8-1:0] s_axil_wstrb,
  input  logic                    s_axil_wvalid,
  output logic                    s_axil_wready,
  output logic [1:0]              s_axil_bresp,
  output logic                    s_axil_bvalid,
  input  logic                    s_axil_bready,
  input  logic [ADDR_WIDTH-1:0]   s_axil_araddr,
  input  logic                    s_axil_arvalid,
  output logic                    s_axil_arready,
  output logic [DATA_WIDTH-1:0]   s_axil_rdata,
  output logic [1:0]              s_axil_rresp,
  output logic                    s_axil_rvalid,
  input  logic                    s_axil_rready
);

  localparam int STRB_WIDTH = DATA_WIDTH / 8;
  localparam int OFFS       = $clog2(STRB_WIDTH);
  localparam int IDX_WIDTH  = ADDR_WIDTH - OFFS;
  localparam int MEM_AW     = $clog2(DEPTH);
  localparam logic [IDX_WIDTH:0] DEPTH_W = (IDX_WIDTH + 1)'(DEPTH);
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {W_IDLE, W_COMMIT, W_RESP} w_state_t;
  typedef enum logic {R_IDLE, R_DATA} r_state_t;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  w_state_t              w_state;
  logic [IDX_WIDTH-1:0]  aw_idx;
  logic [DATA_WIDTH-1:0] w_data;
  logic [STRB_WIDTH-1:0] w_strb;
  logic                  aw_held;
  logic                  w_held;

  r_state_t              r_state;
  logic [IDX_WIDTH-1:0]  ar_idx;
  logic                  ar_held;

  // Byte-offset bits never select anything; only the word index matters.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{s_axil_awaddr[OFFS-1:0], s_axil_araddr[OFFS-1:0]};

  function automatic logic in_range(input logic [IDX_WIDTH-1:0] idx);
    return {1'b0, idx} < DEPTH_W;
  endfunction

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      w_state        <= W_IDLE;
      aw_idx         <= '0;
      w_data         <= '0;
      w_strb         <= '0;
      aw_held        <= 1'b0;
      w_held         <= 1'b0;
      s_axil_awready <= 1'b0;
      s_axil_wready  <= 1'b0;
      s_axil_bvalid  <= 1'b0;
      s_axil_bresp   <= RESP_OKAY;
    end else begin
      case (w_state)
        W_IDLE: begin
          if (s_axil_awvalid && s_axil_awready) begin
            aw_idx         <= s_axil_awaddr[ADDR_WIDTH-1:OFFS];
            aw_held        <= 1'b1;
            s_axil_awready <= 1'b0;
          end else if (!aw_held) begin
            s_axil_awready <= 1'b1;
          end
          if (s_axil_wvalid && s_axil_wready) begin
            w_data        <= s_axil_wdata;
            w_strb        <= s_axil_wstrb;
            w_held        <= 1'b1;
            s_axil_wready <= 1'b0;
          end else if (!w_held) begin
            s_axil_wready <= 1'b1;
          end
          if (aw_held && w_held) w_state <= W_COMMIT;
        end
        W_COMMIT: begin
          s_axil_bvalid <= 1'b1;
          s_axil_bresp  <= in_range(aw_idx) ? RESP_OKAY : RESP_SLVERR;
          w_state       <= W_RESP;
        end
        W_RESP: begin
          if (s_axil_bready) begin
            s_axil_bvalid  <= 1'b0;
            aw_held        <= 1'b0;
            w_held         <= 1'b0;
            s_axil_awready <= 1'b1;
            s_axil_wready  <= 1'b1;
            w_state        <= W_IDLE;
          end
        end
        default: w_state <= W_IDLE;
      endcase
    end
  end

  // Array is left unreset; the commit state is only reachable out of reset.
  always_ff @(posedge aclk) begin
    if (w_state == W_COMMIT && in_range(aw_idx)) begin
      for (int i = 0; i < STRB_WIDTH; i++) begin
        if (w_strb[i]) mem[aw_idx[MEM_AW-1:0]][8*i +: 8] <= w_data[8*i +: 8];
      end
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_state        <= R_IDLE;
      ar_idx         <= '0;
      ar_held        <= 1'b0;
      s_axil_arready <= 1'b0;
      s_axil_rvalid  <= 1'b0;
      s_axil_rresp   <= RESP_OKAY;
      s_axil_rdata   <= '0;
    end else begin
      case (r_state)
        R_IDLE: begin
          if (ar_held) begin
            ar_held       <= 1'b0;
            s_axil_rvalid <= 1'b1;
            r_state       <= R_DATA;
            if (in_range(ar_idx)) begin
              s_axil_rdata <= mem[ar_idx[MEM_AW-1:0]];
              s_axil_rresp <= RESP_OKAY;
            end else begin
              s_axil_rdata <= '0;
              s_axil_rresp <= RESP_SLVERR;
            end
          end else if (s_axil_arvalid && s_axil_arready) begin
            ar_idx         <= s_axil_araddr[ADDR_WIDTH-1:OFFS];
            ar_held        <= 1'b1;
            s_axil_arready <= 1'b0;
          end else begin
            s_axil_arready <= 1'b1;
          end
        end
        R_DATA: begin
          if (s_axil_rready) begin
            s_axil_rvalid  <= 1'b0;
            s_axil_rdata   <= '0;
            s_axil_arready <= 1'b1;
            r_state        <= R_IDLE;
          end
        end
        default: r_state <= R_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axil_ram_strb.sv
// Bench for axil_ram_strb: vector table through a response scoreboard plus hand-built corner sequences.
module tb_axil_ram_strb;

  logic        aclk = 1'b0;
  logic        aresetn = 1'b0;
  logic [15:0] s_axil_awaddr = '0;
  logic        s_axil_awvalid = 1'b0;
  logic        s_axil_awready;
  logic [31:0] s_axil_wdata = '0;
  logic [3:0]  s_axil_wstrb = '0;
  logic        s_axil_wvalid = 1'b0;
  logic        s_axil_wready;
  logic [1:0]  s_axil_bresp;
  logic        s_axil_bvalid;
  logic        s_axil_bready = 1'b0;
  logic [15:0] s_axil_araddr = '0;
  logic        s_axil_arvalid = 1'b0;
  logic        s_axil_arready;
  logic [31:0] s_axil_rdata;
  logic [1:0]  s_axil_rresp;
  logic        s_axil_rvalid;
  logic        s_axil_rready = 1'b0;

  axil_ram_strb #(.DATA_WIDTH(32), .ADDR_WIDTH(16), .DEPTH(1024)) dut (
    .aclk(aclk), .aresetn(aresetn),
    .s_axil_awaddr(s_axil_awaddr), .s_axil_awvalid(s_axil_awvalid), .s_axil_awready(s_axil_awready),
    .s_axil_wdata(s_axil_wdata), .s_axil_wstrb(s_axil_wstrb), .s_axil_wvalid(s_axil_wvalid),
    .s_axil_wready(s_axil_wready), .s_axil_bresp(s_axil_bresp), .s_axil_bvalid(s_axil_bvalid),
    .s_axil_bready(s_axil_bready), .s_axil_araddr(s_axil_araddr), .s_axil_arvalid(s_axil_arvalid),
    .s_axil_arready(s_axil_arready), .s_axil_rdata(s_axil_rdata), .s_axil_rresp(s_axil_rresp),
    .s_axil_rvalid(s_axil_rvalid), .s_axil_rready(s_axil_rready)
  );

  always #5 aclk = ~aclk;

  int cyc = 0;
  always @(posedge aclk) cyc <= cyc + 1;

  int vectors = 0;
  int miscompares = 0;

  typedef struct packed {
    logic [1:0]  resp;
    logic [31:0] data;
  } rexp_t;

  logic [1:0] bq[$];
  rexp_t      rq[$];

  typedef struct {
    bit          wr;
    logic [15:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
    logic [1:0]  resp;
    logic [31:0] rdata;
  } vec_t;

  localparam int NVEC = 19;
  vec_t vt[NVEC];

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  // Scoreboard side: pop on the cycle whose next edge completes the handshake.
  logic [1:0] eb;
  rexp_t      er;
  always @(negedge aclk) begin
    if (aresetn && s_axil_bvalid && s_axil_bready) begin
      if (bq.size() == 0) begin
        vectors++; miscompares++;
        $display("FAIL unexpected_b: got bresp %0b, expected no response", s_axil_bresp);
      end else begin
        eb = bq.pop_front();
        check("bresp", {62'd0, s_axil_bresp}, {62'd0, eb});
      end
    end
    if (aresetn && s_axil_rvalid && s_axil_rready) begin
      if (rq.size() == 0) begin
        vectors++; miscompares++;
        $display("FAIL unexpected_r: got rdata %0h, expected no response", s_axil_rdata);
      end else begin
        er = rq.pop_front();
        check("rresp", {62'd0, s_axil_rresp}, {62'd0, er.resp});
        check("rdata", {32'd0, s_axil_rdata}, {32'd0, er.data});
      end
    end
  end

  task automatic do_write(input logic [15:0] a, input logic [31:0] d, input logic [3:0] s,
                          input logic [1:0] resp);
    bit aw_done = 0, w_done = 0, aw_hs, w_hs;
    int n = 0, hs_cyc = 0;
    bq.push_back(resp);
    s_axil_awaddr = a; s_axil_awvalid = 1'b1;
    s_axil_wdata = d; s_axil_wstrb = s; s_axil_wvalid = 1'b1;
    s_axil_bready = 1'b1;
    while (!(aw_done && w_done) && n < 20) begin
      @(negedge aclk);
      aw_hs = s_axil_awvalid && s_axil_awready;
      w_hs  = s_axil_wvalid && s_axil_wready;
      @(posedge aclk); #1;
      if (aw_hs) begin s_axil_awvalid = 1'b0; aw_done = 1; hs_cyc = cyc; end
      if (w_hs)  begin s_axil_wvalid = 1'b0;  w_done = 1;  hs_cyc = cyc; end
      n++;
    end
    if (!(aw_done && w_done)) begin
      vectors++; miscompares++;
      $display("FAIL aw_w_handshake: got timeout, expected both handshakes");
    end
    s_axil_awvalid = 1'b0; s_axil_wvalid = 1'b0;
    n = 0;
    do begin @(negedge aclk); n++; end while (!s_axil_bvalid && n < 20);
    check("b_latency", 64'(cyc - hs_cyc), 64'd2);
    @(posedge aclk); #1;
    s_axil_bready = 1'b0;
  endtask

  task automatic do_read(input logic [15:0] a, input logic [1:0] resp, input logic [31:0] d);
    int n = 0, hs_cyc = 0;
    rq.push_back('{resp: resp, data: d});
    s_axil_araddr = a; s_axil_arvalid = 1'b1; s_axil_rready = 1'b1;
    do begin @(negedge aclk); n++; end while (!s_axil_arready && n < 20);
    @(posedge aclk); #1;
    hs_cyc = cyc;
    s_axil_arvalid = 1'b0;
    n = 0;
    do begin @(negedge aclk); n++; end while (!s_axil_rvalid && n < 20);
    check("r_latency", 64'(cyc - hs_cyc), 64'd1);
    @(posedge aclk); #1;
    s_axil_rready = 1'b0;
  endtask

  task automatic check_all_zero(input string nm);
    check(nm, {21'd0, s_axil_awready, s_axil_wready, s_axil_bvalid, s_axil_bresp,
               s_axil_arready, s_axil_rvalid, s_axil_rresp, s_axil_rdata}, 64'd0);
  endtask

  task automatic wait_b(input string nm);
    int n = 0;
    do begin @(negedge aclk); n++; end while (!s_axil_bvalid && n < 20);
    check(nm, {63'd0, s_axil_bvalid}, 64'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish, expected completion");
    $fatal(1);
  end

  initial begin
    vt[0]  = '{1'b1, 16'h0000, 32'h55AA55AA, 4'hF, 2'b00, 32'h0};
    vt[1]  = '{1'b1, 16'h0010, 32'hDEADBEEF, 4'hF, 2'b00, 32'h0};
    vt[2]  = '{1'b0, 16'h0010, 32'h0,        4'h0, 2'b00, 32'hDEADBEEF};
    vt[3]  = '{1'b1, 16'h0020, 32'h11223344, 4'hF, 2'b00, 32'h0};
    vt[4]  = '{1'b1, 16'h0020, 32'hAABBCCDD, 4'h5, 2'b00, 32'h0};
    vt[5]  = '{1'b0, 16'h0020, 32'h0,        4'h0, 2'b00, 32'h11BB33DD};
    vt[6]  = '{1'b1, 16'h0024, 32'hCAFEF00D, 4'hF, 2'b00, 32'h0};
    vt[7]  = '{1'b1, 16'h0024, 32'h12345678, 4'h0, 2'b00, 32'h0};
    vt[8]  = '{1'b0, 16'h0024, 32'h0,        4'h0, 2'b00, 32'hCAFEF00D};
    vt[9]  = '{1'b1, 16'h0FFC, 32'h0BADC0DE, 4'hF, 2'b00, 32'h0};
    vt[10] = '{1'b0, 16'h0FFE, 32'h0,        4'h0, 2'b00, 32'h0BADC0DE};
    vt[11] = '{1'b1, 16'h1000, 32'hFFFFFFFF, 4'hF, 2'b10, 32'h0};
    vt[12] = '{1'b0, 16'h1000, 32'h0,        4'h0, 2'b10, 32'h0};
    vt[13] = '{1'b0, 16'h0000, 32'h0,        4'h0, 2'b00, 32'h55AA55AA};
    vt[14] = '{1'b1, 16'h0022, 32'h99887766, 4'hA, 2'b00, 32'h0};
    vt[15] = '{1'b0, 16'h0020, 32'h0,        4'h0, 2'b00, 32'h99BB77DD};
    vt[16] = '{1'b1, 16'h8000, 32'h12121212, 4'hF, 2'b10, 32'h0};
    vt[17] = '{1'b0, 16'hFFFC, 32'h0,        4'h0, 2'b10, 32'h0};
    vt[18] = '{1'b0, 16'h0000, 32'h0,        4'h0, 2'b00, 32'h55AA55AA};

    #12;
    check_all_zero("reset_outputs");
    @(negedge aclk);
    aresetn = 1'b1;
    #1;
    check("ready_before_edge", {61'd0, s_axil_awready, s_axil_wready, s_axil_arready}, 64'd0);
    @(posedge aclk); #1;
    check("ready_after_release", {61'd0, s_axil_awready, s_axil_wready, s_axil_arready}, 64'd7);

    for (int i = 0; i < NVEC; i++) begin
      if (vt[i].wr) do_write(vt[i].addr, vt[i].data, vt[i].strb, vt[i].resp);
      else          do_read(vt[i].addr, vt[i].resp, vt[i].rdata);
    end

    // W leads AW by five cycles, then B is held off for three cycles.
    s_axil_wdata = 32'h0F1E2D3C; s_axil_wstrb = 4'hF; s_axil_wvalid = 1'b1; s_axil_bready = 1'b0;
    @(posedge aclk); #1;
    s_axil_wvalid = 1'b0;
    check("w_only_wready", {63'd0, s_axil_wready}, 64'd0);
    repeat (4) @(posedge aclk);
    #1;
    check("decoupled_wait", {61'd0, s_axil_awready, s_axil_wready, s_axil_bvalid}, 64'b100);
    s_axil_awaddr = 16'h0040; s_axil_awvalid = 1'b1;
    bq.push_back(2'b00);
    @(posedge aclk); #1;
    s_axil_awvalid = 1'b0;
    wait_b("decoupled_bvalid");
    repeat (3) begin
      @(negedge aclk);
      check("b_held", {59'd0, s_axil_bvalid, s_axil_bresp, s_axil_awready, s_axil_wready}, 64'b10000);
    end
    @(posedge aclk); #1;
    s_axil_bready = 1'b1;
    @(posedge aclk); #1;
    check("b_release", {61'd0, s_axil_bvalid, s_axil_awready, s_axil_wready}, 64'b011);
    s_axil_bready = 1'b0;
    do_read(16'h0040, 2'b00, 32'h0F1E2D3C);

    // Write commit and read capture land on the same edge: old data returned.
    s_axil_awaddr = 16'h0010; s_axil_awvalid = 1'b1;
    s_axil_wdata = 32'h01020304; s_axil_wstrb = 4'hF; s_axil_wvalid = 1'b1;
    s_axil_bready = 1'b1; s_axil_rready = 1'b1;
    bq.push_back(2'b00);
    @(posedge aclk); #1;
    s_axil_awvalid = 1'b0; s_axil_wvalid = 1'b0;
    s_axil_araddr = 16'h0010; s_axil_arvalid = 1'b1;
    rq.push_back('{resp: 2'b00, data: 32'hDEADBEEF});
    @(posedge aclk); #1;
    s_axil_arvalid = 1'b0;
    repeat (4) @(posedge aclk);
    #1;
    s_axil_bready = 1'b0; s_axil_rready = 1'b0;
    do_read(16'h0010, 2'b00, 32'h01020304);

    // Read data must hold while rready is low.
    rq.push_back('{resp: 2'b00, data: 32'h01020304});
    s_axil_araddr = 16'h0010; s_axil_arvalid = 1'b1; s_axil_rready = 1'b0;
    @(posedge aclk); #1;
    s_axil_arvalid = 1'b0;
    @(posedge aclk); #1;
    repeat (4) begin
      @(negedge aclk);
      check("r_stall", {28'd0, s_axil_arready, s_axil_rvalid, s_axil_rresp, s_axil_rdata},
            {28'd0, 1'b0, 1'b1, 2'b00, 32'h01020304});
    end
    @(posedge aclk); #1;
    s_axil_rready = 1'b1;
    @(posedge aclk); #1;
    check("r_release", {30'd0, s_axil_rvalid, s_axil_arready, s_axil_rdata}, {30'd0, 2'b01, 32'd0});
    s_axil_rready = 1'b0;

    // Reset lands after AW is accepted but before W arrives.
    do_write(16'h0030, 32'h13579BDF, 4'hF, 2'b00);
    s_axil_awaddr = 16'h0030; s_axil_awvalid = 1'b1; s_axil_wdata = 32'hFFFFFFFF;
    @(posedge aclk); #1;
    s_axil_awvalid = 1'b0;
    check("aw_held_pre_reset", {63'd0, s_axil_awready}, 64'd0);
    #2;
    aresetn = 1'b0;
    #1;
    check_all_zero("reset_mid_write");
    @(negedge aclk);
    aresetn = 1'b1;
    @(posedge aclk); #1;
    check("ready_after_reset", {61'd0, s_axil_awready, s_axil_wready, s_axil_arready}, 64'd7);
    repeat (5) @(posedge aclk);
    #1;
    check("no_b_after_reset", {63'd0, s_axil_bvalid}, 64'd0);
    do_read(16'h0030, 2'b00, 32'h13579BDF);

    repeat (3) @(posedge aclk);
    check("queues_drained", 64'(bq.size() + rq.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
